// File: rtl/uart_pkg.sv
// Shared UART definitions: frame states, legal parameter ranges and the
// baud divisor computation used by both the TX and the future RX path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam int unsigned DATA_BITS_MIN  = 5;
    localparam int unsigned DATA_BITS_MAX  = 9;
    localparam int unsigned STOP_BITS_MIN  = 1;
    localparam int unsigned STOP_BITS_MAX  = 2;
    localparam int unsigned OVERSAMPLE_MIN = 2;

    // System clocks per oversample tick, truncated; 0 flags an unusable setting.
    function automatic int unsigned uart_div(input int unsigned sys_clk,
                                             input int unsigned baud,
                                             input int unsigned oversample);
        if ((baud * oversample) == 0) begin
            return 0;
        end
        return sys_clk / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampled baud tick generator. Emits a one-cycle tick each time the
// divider wraps from DIV-1 to 0; clr restarts the phase so a frame begins
// exactly on a fresh tick boundary.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned SYS_CLK    = 100_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned DIV = uart_div(SYS_CLK, BAUD, OVERSAMPLE);
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

    if (DIV < 1) begin : g_bad_div
        $error("uart_baud_tick: SYS_CLK / (BAUD * OVERSAMPLE) must be at least 1");
    end

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          wrap;

    // Next divider value and tick decode; a clear suppresses the tick.
    always_comb begin
        wrap = (cnt_q == CW'(DIV - 1));
        tick = wrap && !clr;
        if (clr || wrap) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Divider counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: valid/ready byte intake, LSB-first
// serialisation with optional parity and one or two stop bits.
//
//   state  | meaning
//   -------+-----------------------------------------------
//   IDLE   | line high, o_ready high, waiting for i_valid
//   START  | driving the start bit (low)
//   DATA   | driving shift[0], one payload bit per period
//   PARITY | driving the parity bit captured at accept
//   STOP   | line high for STOP_BITS periods, then o_done
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int unsigned SYS_CLK    = 100_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] i_data,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 tx
);

    localparam int unsigned BW = $clog2(DATA_BITS + 1);
    localparam int unsigned OW = $clog2(OVERSAMPLE);

    if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
        $error("uart_tx_param: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (OVERSAMPLE < OVERSAMPLE_MIN) begin : g_bad_oversample
        $error("uart_tx_param: OVERSAMPLE must be at least 2");
    end

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [OW-1:0]        os_cnt_q, os_cnt_d;
    logic                 tx_q, tx_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 accept;
    logic                 tick;
    logic                 bit_end;

    assign accept = i_valid && ready_q;

    uart_baud_tick #(
        .SYS_CLK    (SYS_CLK),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_baud_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .tick (tick)
    );

    // Frame sequencing: next state, shift/parity capture and next line level.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        bit_end = tick && (os_cnt_q == OW'(OVERSAMPLE - 1));

        if (state_q == IDLE || accept) begin
            os_cnt_d = '0;
        end else if (tick) begin
            os_cnt_d = (os_cnt_q == OW'(OVERSAMPLE - 1)) ? '0 : os_cnt_q + OW'(1);
        end else begin
            os_cnt_d = os_cnt_q;
        end

        case (state_q)
            IDLE: begin
                tx_d    = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                if (accept) begin
                    state_d   = START;
                    shift_d   = i_data;
                    parity_d  = (^i_data) ^ (PARITY_ODD != 0);
                    bit_cnt_d = '0;
                    tx_d      = 1'b0;
                    ready_d   = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        if (PARITY_EN != 0) begin
                            state_d = PARITY;
                            tx_d    = parity_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        tx_d      = shift_d[0];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d   = STOP;
                    bit_cnt_d = '0;
                    tx_d      = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (bit_cnt_q == BW'(STOP_BITS - 1)) begin
                        state_d   = IDLE;
                        bit_cnt_d = '0;
                        done_d    = 1'b1;
                        ready_d   = 1'b1;
                        busy_d    = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                    tx_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset forces the line high immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            bit_cnt_q <= '0;
            os_cnt_q  <= '0;
            tx_q      <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            bit_cnt_q <= bit_cnt_d;
            os_cnt_q  <= os_cnt_d;
            tx_q      <= tx_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign tx      = tx_q;
    assign o_ready = ready_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;

endmodule
